// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared definitions for the RV32M divide unit.
//   - FUNCT3 encodings for DIV/DIVU/REM/REMU
//   - divider FSM state encoding
//   - datapath width and special-case result constants
//   - magnitude() helper: two's-complement absolute value for signed ops
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_CALC   = 2'd1,
    DIV_FINISH = 2'd2
  } div_state_e;

  // Absolute value when the operand is treated as signed; INT_MIN maps to
  // itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/rv32m_div_step.sv
// rv32m_div_step: one combinational radix-2 restoring division iteration.
// Ports:
//   rem      in  XLEN  partial remainder (always < divisor)
//   quo      in  XLEN  dividend bits still to shift in / quotient bits so far
//   divisor  in  XLEN  unsigned divisor magnitude
//   rem_next out XLEN  partial remainder after this step
//   quo_next out XLEN  quotient register after this step
module rv32m_div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted remainder needs XLEN+1 bits: rem < divisor, so after the
  // shift it is < 2*divisor and the difference, when non-negative, fits XLEN.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// rv32m_div_unit: iterative radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU in the EX stage.
// Ports:
//   CLK        in  1       clock, posedge
//   RST        in  1       synchronous active-high reset
//   START      in  1       request; sampled only while BUSY=0
//   FUNCT3     in  3       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   OPERAND_A  in  XLEN    dividend (rs1)
//   OPERAND_B  in  XLEN    divisor (rs2)
//   DEST_REG   in  REG_AW  rd index, returned on RESULT_REG
//   FLUSH      in  1       abort the operation in flight
//   BUSY       out 1       operation in progress (pipeline stall)
//   DONE       out 1       one-cycle pulse, RESULT/RESULT_REG valid
//   RESULT     out XLEN    quotient or remainder, held until next DONE
//   RESULT_REG out REG_AW  rd for writeback
//   DBG_STATE  out 2       current FSM state (div_state_e encoding)
// Handshake: an op is accepted on a posedge where BUSY=0, START=1,
// FUNCT3[2]=1 and FLUSH=0; exactly one DONE pulse follows unless the op is
// flushed or reset. RST > FLUSH > START.
// Build option: define DIV_FASTPATH_EN to finish divide-by-zero, signed
// overflow and |A|<|B| one cycle after accept instead of after 32 steps.
// Only XLEN=32 is supported.
module rv32m_div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [2:0]        FUNCT3,
  input  logic [XLEN-1:0]   OPERAND_A,
  input  logic [XLEN-1:0]   OPERAND_B,
  input  logic [REG_AW-1:0] DEST_REG,
  input  logic              FLUSH,
  output logic              BUSY,
  output logic              DONE,
  output logic [XLEN-1:0]   RESULT,
  output logic [REG_AW-1:0] RESULT_REG,
  output logic [1:0]        DBG_STATE
);

  div_state_e        state;
  logic [5:0]        cnt;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   divisor_q;
  logic              is_signed_q;
  logic              sel_rem_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              div0_q;
  logic [REG_AW-1:0] dest_q;

  assign DBG_STATE = state;

  // ---------------- accept-side decode ----------------
  logic            is_signed_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            accept;

  assign is_signed_in = ~FUNCT3[0];
  assign mag_a        = magnitude(OPERAND_A, is_signed_in);
  assign mag_b        = magnitude(OPERAND_B, is_signed_in);
  assign accept       = (state == DIV_IDLE) && START && FUNCT3[2] && !FLUSH;

  // Fast-path preload: quo/rem are loaded with the final magnitudes so the
  // FINISH sign logic is shared with the iterative path.
  logic            fast_hit;
  logic [XLEN-1:0] fast_quo;
  logic [XLEN-1:0] fast_rem;

`ifdef DIV_FASTPATH_EN
  logic b_zero;
  logic ovf;
  logic small;

  assign b_zero   = (OPERAND_B == '0);
  assign ovf      = is_signed_in && (OPERAND_A == INT_MIN) && (OPERAND_B == '1);
  assign small    = (mag_a < mag_b);
  assign fast_hit = b_zero | ovf | small;
  assign fast_quo = b_zero ? DIV0_QUOTIENT : (ovf ? INT_MIN : '0);
  assign fast_rem = ovf ? '0 : mag_a;
`else
  assign fast_hit = 1'b0;
  assign fast_quo = '0;
  assign fast_rem = '0;
`endif

  // ---------------- iteration datapath ----------------
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  rv32m_div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // ---------------- finish-side sign correction ----------------
  logic [XLEN-1:0] q_final;
  logic [XLEN-1:0] r_final;
  logic [XLEN-1:0] result_sel;

  always_comb begin
    q_final = quo_q;
    if (is_signed_q && (a_neg_q ^ b_neg_q)) q_final = ~quo_q + XLEN'(1);
    // B=0 must give all ones regardless of the dividend sign.
    if (div0_q) q_final = DIV0_QUOTIENT;
    // Remainder takes the dividend sign; for B=0 this restores A exactly.
    r_final = rem_q;
    if (is_signed_q && a_neg_q) r_final = ~rem_q + XLEN'(1);
    result_sel = sel_rem_q ? r_final : q_final;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      is_signed_q <= 1'b0;
      sel_rem_q   <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      dest_q      <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      RESULT      <= '0;
      RESULT_REG  <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            is_signed_q <= is_signed_in;
            sel_rem_q   <= FUNCT3[1];
            a_neg_q     <= OPERAND_A[XLEN-1];
            b_neg_q     <= OPERAND_B[XLEN-1];
            div0_q      <= (OPERAND_B == '0);
            dest_q      <= DEST_REG;
            divisor_q   <= mag_b;
            cnt         <= '0;
            BUSY        <= 1'b1;
            if (fast_hit) begin
              quo_q <= fast_quo;
              rem_q <= fast_rem;
              state <= DIV_FINISH;
            end else begin
              quo_q <= mag_a;
              rem_q <= '0;
              state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          if (FLUSH) begin
            state <= DIV_IDLE;
            BUSY  <= 1'b0;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + 6'd1;
            if (cnt == 6'd31) state <= DIV_FINISH;
          end
        end
        DIV_FINISH: begin
          state <= DIV_IDLE;
          BUSY  <= 1'b0;
          if (!FLUSH) begin
            RESULT     <= result_sel;
            RESULT_REG <= dest_q;
            DONE       <= 1'b1;
          end
        end
        default: begin
          state <= DIV_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// tb_rv32m_div_unit: directed self-checking bench for rv32m_div_unit.
// Stimulus pushes {rd, result} into exp_q at issue; a negedge monitor pops
// and compares on every DONE. Latency, flush, reset and ignore-while-busy
// behaviour are checked from the stimulus process.
module tb_rv32m_div_unit;
  import rv32m_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [2:0]  FUNCT3 = 3'b0;
  logic [31:0] OPERAND_A = '0;
  logic [31:0] OPERAND_B = '0;
  logic [4:0]  DEST_REG = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic [4:0]  RESULT_REG;
  logic [1:0]  DBG_STATE;

  rv32m_div_unit #(.XLEN(32), .REG_AW(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .FUNCT3     (FUNCT3),
    .OPERAND_A  (OPERAND_A),
    .OPERAND_B  (OPERAND_B),
    .DEST_REG   (DEST_REG),
    .FLUSH      (FLUSH),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .RESULT_REG (RESULT_REG),
    .DBG_STATE  (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int FULL_LAT = 33;
`ifdef DIV_FASTPATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 33;
`endif

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          t0 = 0;
  logic [36:0] mon_e;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (DONE) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: DONE with RESULT 0x%08h rd %0d, nothing expected",
                 RESULT, RESULT_REG);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", RESULT, mon_e[31:0]);
        check("result_reg", {27'b0, RESULT_REG}, {27'b0, mon_e[36:32]});
      end
      if (prev_done) begin
        checks++;
        $display("FAIL done_twice: DONE high 2 consecutive cycles, expected 1");
      end
    end
    prev_done = DONE;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge E0.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit push);
    int guard = 0;
    while (BUSY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    START = 1'b1; FUNCT3 = f3; OPERAND_A = a; OPERAND_B = b; DEST_REG = rd;
    if (push) exp_q.push_back({rd, exp});
    @(posedge CLK);
    #1;
    t0 = cyc;
    START = 1'b0;
    @(negedge CLK);
    check("busy_after_accept", {31'b0, BUSY}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    while (!DONE && (cyc - t0) < 100) @(negedge CLK);
    if (!DONE) begin
      checks++;
      $display("FAIL %s_timeout: no DONE within 100 cycles, expected after %0d", name, exp_lat);
    end else begin
      check({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
      check({name, "_busy_in_done"}, {31'b0, BUSY}, 32'd0);
    end
  endtask

  task automatic watch_no_done(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge CLK);
      if (DONE) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, {31'b0, BUSY}, 32'd0);
    check({name, "_done"}, {31'b0, DONE}, 32'd0);
    check({name, "_result"}, RESULT, 32'd0);
    check({name, "_result_reg"}, {27'b0, RESULT_REG}, 32'd0);
    check({name, "_state"}, {30'b0, DBG_STATE}, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV] = '{
    '{F3_DIV,  32'd20,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFA, 1'b0},
    '{F3_REM,  32'hFFFF_FFEC, 32'd3,         5'd6,  32'hFFFF_FFFE, 1'b0},
    '{F3_REMU, 32'd100,       32'd7,         5'd7,  32'd2,         1'b0},
    '{F3_DIVU, 32'd7,         32'd0,         5'd8,  32'hFFFF_FFFF, 1'b1},
    '{F3_REMU, 32'd7,         32'd0,         5'd9,  32'd7,         1'b1},
    '{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1},
    '{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1'b1},
    '{F3_DIV,  32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, 1'b0},
    '{F3_REM,  32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 1'b0},
    '{F3_DIV,  32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1},
    '{F3_REM,  32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9, 1'b1},
    '{F3_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd31, 32'hFFFF_FFFF, 1'b0},
    '{F3_DIVU, 32'd3,         32'd10,        5'd1,  32'd0,         1'b1},
    '{F3_REMU, 32'd3,         32'd10,        5'd2,  32'd3,         1'b1}
  };

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge CLK);
    check_cleared("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Back-to-back: each issue happens in the previous op's DONE cycle.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
      wait_done($sformatf("v%0d", i), vecs[i].fast ? FAST_LAT : FULL_LAT);
    end

    // START while BUSY with different operands is ignored.
    issue(F3_DIV, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
    repeat (4) @(negedge CLK);
    START = 1'b1; FUNCT3 = F3_DIVU; OPERAND_A = 32'd50; OPERAND_B = 32'd5; DEST_REG = 5'd9;
    repeat (3) @(negedge CLK);
    START = 1'b0;
    wait_done("ignore_busy", FULL_LAT);

    // FLUSH in CALC: no DONE, RESULT keeps 14 / rd 3.
    issue(F3_DIV, 32'd100, 32'd10, 5'd4, 32'd10, 1'b0);
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("flush_busy", {31'b0, BUSY}, 32'd0);
    check("flush_state", {30'b0, DBG_STATE}, 32'd0);
    check("flush_result", RESULT, 32'd14);
    check("flush_result_reg", {27'b0, RESULT_REG}, 32'd3);
    watch_no_done("flush_no_done", 40);

    // FLUSH with START in IDLE drops the START.
    START = 1'b1; FUNCT3 = F3_DIV; OPERAND_A = 32'd9; OPERAND_B = 32'd3; DEST_REG = 5'd20;
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("flush_start_dropped", {31'b0, BUSY}, 32'd0);
    watch_no_done("flush_start_no_done", 5);

    issue(F3_DIVU, 32'd9, 32'd2, 5'd7, 32'd4, 1'b1);
    wait_done("after_flush", FULL_LAT);

    // Reset mid-CALC clears all outputs, no DONE afterwards.
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd8, 32'd333, 1'b0);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_cleared("mid_reset");
    watch_no_done("reset_no_done", 40);

    issue(F3_DIVU, 32'd5, 32'd0, 5'd2, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_5_0", FAST_LAT);

    repeat (3) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv32m_div_unit.md
Name: rv32m_div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the EX stage. It consumes the two operands read from the register file through the ID/EX register.
- It produces a 32-bit result and a destination register index for the writeback path, which feeds the register file write port.
- The pipeline stalls on BUSY until DONE.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- REG_AW, 5, destination register index width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  request a division; sampled only when BUSY=0.
- FUNCT3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  in  XLEN  dividend (rs1 data).
- OPERAND_B  in  XLEN  divisor (rs2 data).
- DEST_REG  in  REG_AW  rd index, carried through to RESULT_REG.
- FLUSH  in  1  abort the operation in flight (branch mispredict/trap).
- BUSY  out  1  operation in progress; pipeline stall request.
- DONE  out  1  one-cycle pulse; RESULT/RESULT_REG valid.
- RESULT  out  XLEN  quotient or remainder.
- RESULT_REG  out  REG_AW  rd for writeback.

Behaviour:
- Reset: RST high at a posedge forces IDLE. BUSY=0, DONE=0, RESULT=0, RESULT_REG=0, and all internal registers are cleared. Reset mid-operation aborts with no DONE.
- States:
  - IDLE: START=1, FUNCT3[2]=1 and FLUSH=0 → latch operands, FUNCT3 and DEST_REG, then go to CALC. START with FUNCT3[2]=0 is ignored (multiplies are handled elsewhere).
  - CALC: 32 iterations, one per cycle, with a 6-bit counter 0..31. Each step shifts {rem, quo} left by 1 and trial-subtracts the divisor from rem. If the result is non-negative, rem takes the difference and the quotient LSB is 1.
  - FINISH: 1 cycle. Apply sign correction and result select, register RESULT and RESULT_REG, pulse DONE, return to IDLE.
- Signed ops (DIV/REM): magnitudes are computed from two's complement.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Latency: START sampled at edge E0. BUSY=1 from E0 until DONE. CALC occupies E1..E32. FINISH registers RESULT at E33, DONE=1 for the cycle after E33, and BUSY=0 in that same cycle. Total: 33 cycles, 34 edges to next accept.
- Back-to-back: START may be asserted in the DONE cycle; it is accepted because BUSY=0.
- START while BUSY=1 is ignored; the operands are not re-latched.
- RESULT/RESULT_REG hold their value until the next DONE; DONE is never asserted for 2 consecutive cycles.
- Divide by zero (B=0): quotient=0xFFFFFFFF for both DIV and DIVU; remainder=A. No exception is raised.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- FLUSH: in CALC/FINISH it returns the unit to IDLE at the next edge, with no DONE and RESULT unchanged. In IDLE, FLUSH with START in the same cycle means START is dropped.
- Precedence: RST > FLUSH > START.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined: in IDLE, divide-by-zero, signed overflow, and unsigned |A|<|B| are detected combinationally at accept and go straight to FINISH.
  - For these cases DONE appears 1 cycle after the START edge: RESULT at E1, DONE in the cycle after E1.
  - The values are identical to the full path.
- Undefined: all operations take the full 33-cycle latency.

Decomposition:
- Shared package rv32m_pkg:
  - FUNCT3 constants F3_DIV/F3_DIVU/F3_REM/F3_REMU.
  - State encoding DIV_IDLE/DIV_CALC/DIV_FINISH.
  - XLEN constant.
  - Constants DIV0_QUOTIENT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Sub-module: rv32m_div_step, a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Lets the top level stay FSM plus sign logic.

Test Plan:
- DIV A=20, B=0xFFFFFFFD (-3) → RESULT=0xFFFFFFFA (-6), DONE exactly 33 cycles after START, RESULT_REG=DEST_REG.
- REM A=0xFFFFFFEC (-20), B=3 → RESULT=0xFFFFFFFE (-2); REMU A=100, B=7 → RESULT=2.
- DIVU A=7, B=0 → 0xFFFFFFFF; REMU A=7, B=0 → 7; DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM same operands → 0.
- START DIV 100/10, FLUSH at cycle 10 → BUSY=0 next cycle, no DONE, RESULT unchanged. A new START DIVU 9/2 is then accepted → 4.
- START re-asserted with different operands while BUSY → ignored and the original result is produced. START in the DONE cycle → accepted.
- RST mid-CALC → all outputs 0 next cycle, no DONE. With DIV_FASTPATH_EN, DIVU 5/0 → DONE in the cycle after E1 with RESULT=0xFFFFFFFF.
